z16_fetch_unit: RTL and testbench

Instruction-fetch stage of the Z16 core, directly upstream of the instruction memory. Owns the program counter, drives the byte address into the instruction memory, and captures the returned 16-bit instruction into the IF/ID pipeline register consumed by the decoder. Handles stall, branch/jump redirect with flush, and a halt/resume control state machine.

---
 rtl/z16_fetch_unit.sv | 123 ++++++++++++
 tb/tb_z16_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/z16_fetch_unit.sv
// Z16 instruction-fetch stage: program counter, instruction-memory address,
// IF/ID pipeline register, and the BOOT/RUN/HALT control state machine.
module z16_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [15:0] o_imem_addr,
    input  logic [15:0] i_imem_instr,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_addr,
    input  logic        i_halt,
    input  logic        i_resume,
    output logic [15:0] o_instr,
    output logic [15:0] o_pc,
    output logic        o_valid,
    output logic        o_halted,
    output logic [15:0] o_fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] if_pc_q, if_pc_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;

    // Redirect targets are halfword aligned; bit 0 of the request is dropped.
    logic [15:0] redirect_pc;
    assign redirect_pc = {i_redirect_addr[15:1], 1'b0};

    // Next-state logic: every register holds unless a branch below says otherwise.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;
        valid_d = valid_q;
        count_d = count_q;

        case (state_q)
            ST_BOOT: begin
                // Single bubble cycle after reset; all requests are ignored.
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (i_redirect) begin
                    // Taken branch: flush the fetched slot, even when stalled.
                    pc_d    = redirect_pc;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    if (i_halt) begin
                        state_d = ST_HALT;
                    end
                end else if (i_halt) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = ST_HALT;
                end else if (!i_stall) begin
                    instr_d = i_imem_instr;
                    if_pc_d = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 16'd2;
                    count_d = count_q + 16'd1;
                end
            end

            ST_HALT: begin
                // PC may still be retargeted while parked; resume beats halt.
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                if (i_redirect) begin
                    pc_d = redirect_pc;
                end
                if (i_resume) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State registers with synchronous active-low reset overriding everything.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            if_pc_q <= 16'h0000;
            valid_q <= 1'b0;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            if_pc_q <= if_pc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign o_imem_addr   = pc_q;
    assign o_instr       = instr_q;
    assign o_pc          = if_pc_q;
    assign o_valid       = valid_q;
    assign o_halted      = (state_q == ST_HALT);
    assign o_fetch_count = count_q;

endmodule

// File: tb/tb_z16_fetch_unit.sv
// Self-checking bench for z16_fetch_unit: a reference model pushes expected
// post-edge IF/ID state into a queue, popped and compared after each edge.
module tb_z16_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        halt;
    logic        resume;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic        halted;
    logic [15:0] fetch_count;

    z16_fetch_unit #(
        .RESET_PC (16'h0000),
        .NOP_INSTR(16'h0000)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .o_imem_addr    (imem_addr),
        .i_imem_instr   (imem_instr),
        .i_stall        (stall),
        .i_redirect     (redirect),
        .i_redirect_addr(redirect_addr),
        .i_halt         (halt),
        .i_resume       (resume),
        .o_instr        (instr),
        .o_pc           (pc),
        .o_valid        (valid),
        .o_halted       (halted),
        .o_fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: the test-plan words at 0..6, a pattern elsewhere.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 16'h0010;
            16'h0002: mem_word = 16'h0020;
            16'h0004: mem_word = 16'h0519;
            16'h0006: mem_word = 16'h1220;
            default:  mem_word = {a[7:0] ^ 8'h5A, ~a[15:8]};
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] cnt;
        logic [15:0] addr;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state (0=BOOT, 1=RUN, 2=HALT).
    int          m_state;
    logic [15:0] m_pc, m_instr, m_ifpc, m_cnt;
    logic        m_valid;

    // Advance the model by one rising edge for the given inputs.
    task automatic model_edge(input logic r_n, input logic st, input logic rd,
                              input logic [15:0] ra, input logic hl, input logic rs);
        logic [15:0] target;
        target = ra & 16'hFFFE;
        if (!r_n) begin
            m_state = 0; m_pc = 16'h0000; m_instr = 16'h0000;
            m_ifpc = 16'h0000; m_valid = 1'b0; m_cnt = 16'h0000;
        end else if (m_state == 0) begin
            m_instr = 16'h0000; m_valid = 1'b0; m_state = 1;
        end else if (m_state == 2) begin
            m_instr = 16'h0000; m_valid = 1'b0;
            if (rd) m_pc = target;
            if (rs) m_state = 1;
        end else begin
            if (rd || hl) begin
                m_instr = 16'h0000; m_valid = 1'b0;
                if (rd) m_pc = target;
                if (hl) m_state = 2;
            end else if (!st) begin
                m_instr = mem_word(m_pc);
                m_ifpc  = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 16'd2;
                m_cnt   = m_cnt + 16'd1;
            end
        end
    endtask

    // One transaction: drive inputs, queue the expectation, clock, compare.
    task automatic step(input string name, input logic r_n, input logic st, input logic rd,
                        input logic [15:0] ra, input logic hl, input logic rs);
        exp_t e, o;
        rst_n = r_n; stall = st; redirect = rd; redirect_addr = ra; halt = hl; resume = rs;
        model_edge(r_n, st, rd, ra, hl, rs);
        e.instr = m_instr; e.pc = m_ifpc; e.cnt = m_cnt; e.addr = m_pc;
        e.valid = m_valid; e.halted = (m_state == 2);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        check_eq({name, ".instr"},  instr, o.instr);
        check_eq({name, ".pc"},     pc, o.pc);
        check_eq({name, ".valid"},  {15'd0, valid}, {15'd0, o.valid});
        check_eq({name, ".halted"}, {15'd0, halted}, {15'd0, o.halted});
        check_eq({name, ".count"},  fetch_count, o.cnt);
        check_eq({name, ".addr"},   imem_addr, o.addr);
        $display("%s: addr=%h o_pc=%h instr=%h valid=%b halted=%b count=%0d",
                 name, imem_addr, pc, instr, valid, halted, fetch_count);
    endtask

    task automatic run(input string name);
        step(name, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000;
        halt = 1'b0; resume = 1'b0;
        m_state = 0; m_pc = 0; m_instr = 0; m_ifpc = 0; m_cnt = 0; m_valid = 0;
        #2;

        // Reset, with a redirect asserted to show reset wins.
        step("reset0", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step("reset1", 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);

        // BOOT ignores redirect/halt, then four fetches.
        step("boot", 1'b1, 1'b1, 1'b1, 16'h0040, 1'b1, 1'b0);
        run("fetch0");
        check_eq("direct.instr0", instr, 16'h0010);
        run("fetch1");
        run("fetch2");
        run("fetch3");
        check_eq("direct.instr3", instr, 16'h1220);
        check_eq("direct.count4", fetch_count, 16'd4);

        // Stall at PC=8 for three cycles, then release.
        step("stall0", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        step("stall1", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        step("stall2", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        run("unstall");
        check_eq("direct.unstall_pc", pc, 16'h0008);
        run("fetchA");

        // Redirect to odd address with stall at PC=0xC.
        step("redir_odd", 1'b1, 1'b1, 1'b1, 16'h0007, 1'b0, 1'b0);
        check_eq("direct.redir_addr", imem_addr, 16'h0006);
        run("after_redir");

        // PC wrap at top of memory; resume is ignored while running.
        step("redir_top", 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        run("fetch_top");
        check_eq("direct.top_pc", pc, 16'hFFFE);
        step("wrap_resume", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_eq("direct.wrap_pc", pc, 16'h0000);

        // Halt at PC=0x12, redirect while halted, halt+resume, then run.
        step("redir_12", 1'b1, 1'b0, 1'b1, 16'h0012, 1'b0, 1'b0);
        step("halt", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        step("halt_hold", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        step("halt_redir", 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        check_eq("direct.halt_addr", imem_addr, 16'h0000);
        step("resume", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run("resume_fetch");
        check_eq("direct.resume_pc", pc, 16'h0000);
        run("resume_fetch2");

        // Redirect together with halt: both take effect.
        step("redir_halt", 1'b1, 1'b0, 1'b1, 16'h0031, 1'b1, 1'b0);

        // Reset while halted with a redirect pending, then normal restart.
        step("halt_reset", 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        step("boot2", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        run("refetch0");
        run("refetch1");
        check_eq("direct.refetch_instr", instr, 16'h0020);

        if (exp_q.size() != 0) check_eq("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
